// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked ALU with iterative multiply/divide and flagged compare.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op_sel,
    input  logic                 comp_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 bin,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry_out,
    output logic                 borrow_out,
    output logic                 overflow,
    output logic [5:0]           comp_result,
    output logic                 div_by_zero,
    output logic                 illegal_op,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_MUL = 3'd2;
    localparam logic [2:0] c_OP_DIV = 3'd3;
    localparam logic [2:0] c_OP_CMP = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*WIDTH-1:0] r_result;
    logic               r_carry;
    logic               r_borrow;
    logic               r_ovf;
    logic [5:0]         r_comp;
    logic               r_dbz;
    logic               r_ill;
    logic               r_busy;
    logic               r_done;

    // Iteration state: mul uses acc/mcand/mplier; div keeps {rem,quo} in acc
    // and the divisor in the low half of mcand.
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_is_div;

    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH:0]     w_sub_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_eq;
    logic               w_lt;
    logic               w_gt;
    logic               w_start_ok;
    logic               w_long;
    logic               w_last;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_fit;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_calc_nxt;

    assign w_add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign w_sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    assign w_add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub_diff[WIDTH-1] != a[WIDTH-1]);

    assign w_eq = (a == b);
    assign w_lt = comp_mode ? ($signed(a) < $signed(b)) : (a < b);
    assign w_gt = !w_eq && !w_lt;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_long     = (op_sel == c_OP_MUL) || ((op_sel == c_OP_DIV) && (b != '0));
    assign w_last     = (r_cnt == CNT_W'(1));

    assign w_mul_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Restoring step: shift the next dividend bit into the remainder, keep the
    // subtraction only if it did not go negative.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_div_fit   = !w_div_trial[WIDTH];
    assign w_div_nxt   = {(w_div_fit ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_fit};
    assign w_calc_nxt  = r_is_div ? w_div_nxt : w_mul_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && w_long) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)          w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_comp   <= '0;
            r_dbz    <= 1'b0;
            r_ill    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_is_div <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_carry  <= 1'b0;
                r_borrow <= 1'b0;
                r_ovf    <= 1'b0;
                r_comp   <= '0;
                r_dbz    <= 1'b0;
                r_ill    <= 1'b0;
                case (op_sel)
                    c_OP_ADD: begin
                        r_result <= {{WIDTH{1'b0}}, w_add_sum[WIDTH-1:0]};
                        r_carry  <= w_add_sum[WIDTH];
                        r_ovf    <= w_add_ovf;
                        r_done   <= 1'b1;
                    end
                    c_OP_SUB: begin
                        r_result <= {{WIDTH{1'b0}}, w_sub_diff[WIDTH-1:0]};
                        r_borrow <= w_sub_diff[WIDTH];
                        r_ovf    <= w_sub_ovf;
                        r_done   <= 1'b1;
                    end
                    c_OP_MUL: begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_is_div <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                    end
                    c_OP_DIV: begin
                        if (b == '0) begin
                            r_result <= {a, {WIDTH{1'b1}}};
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_acc    <= {{WIDTH{1'b0}}, a};
                            r_mcand  <= {{WIDTH{1'b0}}, b};
                            r_is_div <= 1'b1;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_busy   <= 1'b1;
                        end
                    end
                    c_OP_CMP: begin
                        r_result <= '0;
                        r_comp   <= {w_eq, !w_eq, w_lt, w_lt | w_eq, w_gt, w_gt | w_eq};
                        r_done   <= 1'b1;
                    end
                    default: begin
                        r_result <= '0;
                        r_ill    <= 1'b1;
                        r_done   <= 1'b1;
                    end
                endcase
            end else if (r_state == ST_CALC) begin
                r_cnt    <= r_cnt - CNT_W'(1);
                r_acc    <= w_calc_nxt;
                r_mplier <= r_mplier >> 1;
                if (!r_is_div) begin
                    r_mcand <= r_mcand << 1;
                end
                if (w_last) begin
                    r_result <= w_calc_nxt;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign result      = r_result;
    assign carry_out   = r_carry;
    assign borrow_out  = r_borrow;
    assign overflow    = r_ovf;
    assign comp_result = r_comp;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_ill;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq against a latency/arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, comp_mode, cin, bin;
    logic [2:0]     op_sel;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] result;
    logic           carry_out, borrow_out, overflow, div_by_zero, illegal_op, busy, done;
    logic [5:0]     comp_result;

    logic           s8_start;
    logic [7:0]     s8_a, s8_b;
    logic [15:0]    s8_result;
    logic           s8_cy, s8_bw, s8_ov, s8_dz, s8_il, s8_busy, s8_done;
    logic [5:0]     s8_cmp;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .comp_mode(comp_mode),
        .a(a), .b(b), .cin(cin), .bin(bin), .result(result), .carry_out(carry_out),
        .borrow_out(borrow_out), .overflow(overflow), .comp_result(comp_result),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8_start), .op_sel(3'b010), .comp_mode(1'b0),
        .a(s8_a), .b(s8_b), .cin(1'b0), .bin(1'b0), .result(s8_result), .carry_out(s8_cy),
        .borrow_out(s8_bw), .overflow(s8_ov), .comp_result(s8_cmp),
        .div_by_zero(s8_dz), .illegal_op(s8_il), .busy(s8_busy), .done(s8_done)
    );

    typedef struct packed {
        logic [63:0] res;
        logic        cy, bw, ov;
        logic [5:0]  cmp;
        logic        dz, il;
    } out_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    // Arithmetic meaning of each operation, computed in 64-bit integers.
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic bi, input logic md,
                                  output out_t e, output bit lng);
        longint unsigned ux, uy, us;
        longint          sx, sy, ss, hi, lo;
        logic            lt, gt, eq;
        e   = '0;
        lng = 1'b0;
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        hi  = 2147483647;
        lo  = -hi - 1;
        case (op)
            3'd0: begin
                us = ux + uy + ci;
                e.res = {32'd0, us[31:0]};
                e.cy  = us[32];
                ss = sx + sy + ci;
                e.ov  = (ss > hi) || (ss < lo);
            end
            3'd1: begin
                us = ux - uy - bi;
                e.res = {32'd0, us[31:0]};
                e.bw  = ux < (uy + bi);
                ss = sx - sy - bi;
                e.ov  = (ss > hi) || (ss < lo);
            end
            3'd2: begin
                e.res = ux * uy;
                lng = 1'b1;
            end
            3'd3: begin
                if (y == 0) begin
                    e.res = {x, 32'hFFFF_FFFF};
                    e.dz  = 1'b1;
                end else begin
                    e.res = {x % y, x / y};
                    lng = 1'b1;
                end
            end
            3'd4: begin
                eq = (x == y);
                lt = md ? (sx < sy) : (ux < uy);
                gt = md ? (sx > sy) : (ux > uy);
                e.cmp = {eq, !eq, lt, lt | eq, gt, gt | eq};
            end
            default: e.il = 1'b1;
        endcase
    endfunction

    out_t exp_out = '0;
    out_t pend;
    bit   lng;
    int   remaining = 0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (reset) begin
            exp_out   = '0;
            remaining = 0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                exp_out  = pend;
                exp_done = 1'b1;
            end
        end else if (start) begin
            model(op_sel, a, b, cin, bin, comp_mode, pend, lng);
            if (lng) begin
                remaining = W;
            end else begin
                exp_out  = pend;
                exp_done = 1'b1;
            end
        end
        exp_busy = (remaining > 0);
    end

    out_t act;
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({busy, done} !== {exp_busy, exp_done}) begin
                fails++;
                $display("FAIL ctl @%0t: busy,done got %b%b required %b%b", $time, busy, done, exp_busy, exp_done);
            end
            if (!exp_busy) begin
                act = {result, carry_out, borrow_out, overflow, comp_result, div_by_zero, illegal_op};
                tests++;
                if (act !== exp_out) begin
                    fails++;
                    $display("FAIL out @%0t: got %h required %h", $time, act, exp_out);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] req_v);
        tests++;
        if (act_v !== req_v) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act_v, req_v);
        end
    endtask

    task automatic wait_done(input int k0, output int edges);
        while (!done && (cyc - k0) < 100) @(negedge clk);
        if (!done) begin
            fails++;
            tests++;
            $display("FAIL timeout: done got 0 required 1 within 100 cycles");
        end
        edges = cyc - k0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic bi, input logic md, output int edges);
        int k0;
        @(negedge clk);
        op_sel = op; a = x; b = y; cin = ci; bin = bi; comp_mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k0 = cyc;
        wait_done(k0, edges);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, k0, n_done;
        reset = 1'b1; start = 1'b0; op_sel = 3'd0; comp_mode = 1'b0;
        a = '0; b = '0; cin = 1'b0; bin = 1'b0;
        s8_start = 1'b0; s8_a = '0; s8_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_result", result, 64'd0);
        chk("reset_flags", {carry_out, borrow_out, overflow, comp_result, div_by_zero, illegal_op, busy, done}, 64'd0);
        reset = 1'b0;

        do_op(3'd0, 32'd100, 32'd50, 1'b0, 1'b0, 1'b0, e);
        chk("add_res", result, 64'd150);  chk("add_cy", carry_out, 64'd0);  chk("add_lat", e, 64'd0);
        do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, e);
        chk("add_wrap_res", result, 64'd0); chk("add_wrap_cy", carry_out, 64'd1); chk("add_wrap_ov", overflow, 64'd0);
        do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, e);
        chk("add_ovf_res", result, 64'h8000_0000); chk("add_ovf", overflow, 64'd1);
        do_op(3'd1, 32'd100, 32'd30, 1'b0, 1'b0, 1'b0, e);
        chk("sub_res", result, 64'd70); chk("sub_bw", borrow_out, 64'd0);
        do_op(3'd1, 32'd30, 32'd100, 1'b0, 1'b0, 1'b0, e);
        chk("sub_neg_res", result, 64'hFFFF_FFBA); chk("sub_neg_bw", borrow_out, 64'd1);
        do_op(3'd2, 32'd20, 32'd15, 1'b0, 1'b0, 1'b0, e);
        chk("mul_res", result, 64'd300); chk("mul_lat", e, 64'd32);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, e);
        chk("mul_max", result, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, e);
        chk("div_res", result, 64'h0000_0002_0000_000E); chk("div_lat", e, 64'd32);
        do_op(3'd3, 32'd55, 32'd0, 1'b0, 1'b0, 1'b0, e);
        chk("div0_res", result, 64'h0000_0037_FFFF_FFFF); chk("div0_flag", div_by_zero, 64'd1); chk("div0_lat", e, 64'd0);
        do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, e);
        chk("cmp_unsigned", comp_result, 64'b010011);
        do_op(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, e);
        chk("cmp_signed", comp_result, 64'b011100);
        do_op(3'd4, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, e);
        chk("cmp_equal", comp_result, 64'b100101);
        do_op(3'd6, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, e);
        chk("illegal_flag", illegal_op, 64'd1); chk("illegal_res", result, 64'd0);

        // start pulsed while a multiply is running must be ignored
        @(negedge clk);
        op_sel = 3'd2; a = 32'd20; b = 32'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k0 = cyc;
        repeat (5) @(negedge clk);
        op_sel = 3'd0; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'd7; b = 32'd9;
        wait_done(k0, e);
        chk("mid_start_res", result, 64'd300); chk("mid_start_lat", e, 64'd32);

        // reset partway through a multiply aborts it silently
        @(negedge clk);
        op_sel = 3'd2; a = 32'h0000_FFFF; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {result, busy, done}, 64'd0);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 64'd0);

        @(negedge clk);
        s8_a = 8'd255; s8_b = 8'd255; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0; k0 = cyc;
        while (!s8_done && (cyc - k0) < 100) @(negedge clk);
        chk("w8_mul_res", s8_result, 64'hFE01); chk("w8_mul_lat", cyc - k0, 64'd8);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 2) == 0);
            op_sel    = 3'($urandom_range(0, 7));
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
            bin       = 1'($urandom_range(0, 1));
            comp_mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (50) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
